// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bridge arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN is consumed by bus_arbiter.sv.
package bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 32;
  localparam int HOLD_W     = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_M0   = 2'b01,
    OWNER_M1   = 2'b10
  } owner_e;

  function automatic owner_e owner_of(arb_state_e s);
    case (s)
      ARB_OWN0: return OWNER_M0;
      ARB_OWN1: return OWNER_M1;
      default:  return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and bridge-side signals of the arbiter, grouped with modports
// for the arbiter, the requesting masters and the bridge.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic              m0_req;
  logic              m0_lock;
  logic              m0_wen;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_wen;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;

  logic [DATA_W-1:0] rdata;
  logic              bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_data;
  logic [1:0]        owner;

  modport arb (
    input  m0_req, m0_lock, m0_wen, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_wen, m1_addr, m1_wdata,
    input  bus_data,
    output m0_gnt, m0_ack, m1_gnt, m1_ack,
    output rdata, bus_wen, bus_addr, bus_wdata, owner
  );

  modport masters (
    output m0_req, m0_lock, m0_wen, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_wen, m1_addr, m1_wdata,
    input  m0_gnt, m0_ack, m1_gnt, m1_ack, rdata, owner
  );

  modport bridge (
    input  bus_wen, bus_addr, bus_wdata,
    output bus_data
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the memory/peripheral bridge with lock and bounded hold.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties in favour of the master not served last.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8  // legal range 1..255
) (
  input  logic      clk,
  input  logic      rst,
  bus_arbiter_if.arb bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state;
  arb_state_e        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              gnt0;
  logic              gnt1;
  owner_e            owner;
  logic              ack0;
  logic              ack1;
  logic              release0;
  logic              release1;
  logic              tie_m0;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;

  always_comb tie_m0 = last_m1;
`else
  always_comb tie_m0 = 1'b1;
`endif

  always_comb begin
    ack0 = (state == ARB_OWN0) && bus.m0_req;
    ack1 = (state == ARB_OWN1) && bus.m1_req;
    // Forced release only on an unlocked ack while the other master waits.
    release0 = (!bus.m0_req && !bus.m0_lock) ||
               (ack0 && !bus.m0_lock && bus.m1_req && hold_cnt == HOLD_LAST);
    release1 = (!bus.m1_req && !bus.m1_lock) ||
               (ack1 && !bus.m1_lock && bus.m0_req && hold_cnt == HOLD_LAST);
  end

  always_comb begin
    // NOTE: next_state gets a default before the case so no path infers a latch.
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (bus.m0_req && (!bus.m1_req || tie_m0)) next_state = ARB_OWN0;
        else if (bus.m1_req)                       next_state = ARB_OWN1;
      end
      ARB_OWN0: if (release0) next_state = bus.m1_req ? ARB_OWN1 : ARB_IDLE;
      ARB_OWN1: if (release1) next_state = bus.m0_req ? ARB_OWN0 : ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Bus outputs follow the registered state only, so the async reset of state
  // also kills a write that is in flight.
  always_comb begin
    bus.bus_wen   = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    case (state)
      ARB_OWN0: begin
        bus.bus_wen   = bus.m0_wen & bus.m0_req;
        bus.bus_addr  = bus.m0_addr;
        bus.bus_wdata = bus.m0_wdata;
      end
      ARB_OWN1: begin
        bus.bus_wen   = bus.m1_wen & bus.m1_req;
        bus.bus_addr  = bus.m1_addr;
        bus.bus_wdata = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      owner    <= OWNER_NONE;
      hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1  <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      gnt0  <= (next_state == ARB_OWN0);
      gnt1  <= (next_state == ARB_OWN1);
      owner <= owner_of(next_state);

      if (next_state != state || state == ARB_IDLE)
        hold_cnt <= '0;
      else if ((ack0 || ack1) && hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
      if (next_state == ARB_OWN0 && state != ARB_OWN0)
        last_m1 <= 1'b0;
      else if (next_state == ARB_OWN1 && state != ARB_OWN1)
        last_m1 <= 1'b1;
`endif
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.m0_ack = ack0;
  assign bus.m1_ack = ack1;
  assign bus.owner  = owner;
  assign bus.rdata  = bus.bus_data;

endmodule
